// File: rtl/poly_synth_core.sv
// poly_synth_core: VOICES square-wave oscillators, each shaped by its own ADSR
// envelope, summed and converted to a 1-bit stream by a first-order sigma-delta.
module poly_synth_core #(
   parameter int VOICES   = 4,
   parameter int CNT_W    = 12,
   parameter int ENV_W    = 8,
   parameter int PRESCALE = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_voice,
   input  logic [2:0]        cfg_reg,
   input  logic [CNT_W-1:0]  cfg_wdata,
   input  logic [VOICES-1:0] gate,
   input  logic              mute,
   output logic              data,
   output logic [VOICES-1:0] active
);
   localparam int SUM_W = ENV_W + $clog2(VOICES);
   localparam int DIV_W = $clog2(PRESCALE);
   localparam logic [ENV_W-1:0] ENV_MAX = '1;

   typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} adsr_state_e;

   // Per-voice configuration
   logic [CNT_W-1:0] osc_count_q [VOICES];
   logic [CNT_W-1:0] osc_count_d [VOICES];
   logic [ENV_W-1:0] atk_inc_q   [VOICES];
   logic [ENV_W-1:0] atk_inc_d   [VOICES];
   logic [ENV_W-1:0] dec_dec_q   [VOICES];
   logic [ENV_W-1:0] dec_dec_d   [VOICES];
   logic [ENV_W-1:0] sus_lvl_q   [VOICES];
   logic [ENV_W-1:0] sus_lvl_d   [VOICES];
   logic [ENV_W-1:0] rel_dec_q   [VOICES];
   logic [ENV_W-1:0] rel_dec_d   [VOICES];
   logic [VOICES-1:0] osc_wr;

   // Per-voice oscillator and envelope state
   logic [CNT_W-1:0]  cnt_q [VOICES];
   logic [CNT_W-1:0]  cnt_d [VOICES];
   logic [VOICES-1:0] phase_q, phase_d;
   logic [ENV_W-1:0]  env_q [VOICES];
   logic [ENV_W-1:0]  env_d [VOICES];
   adsr_state_e       state_q [VOICES];
   adsr_state_e       state_d [VOICES];
   logic [VOICES-1:0] gate_prev_q, gate_prev_d;
   logic [VOICES-1:0] active_q, active_d;
   logic [ENV_W:0]    atk_sum  [VOICES];
   logic [ENV_W:0]    dec_diff [VOICES];
   logic [VOICES-1:0] rise;

   // Shared tick divider and modulator
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   logic [SUM_W-1:0] sum;
   logic [SUM_W:0]   acc_sum;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic             data_q, data_d;

   assign tick   = (div_q == DIV_W'(PRESCALE - 1));
   assign div_d  = tick ? '0 : div_q + DIV_W'(1);
   assign data   = data_q;
   assign active = active_q;

   // Out-of-range voice or register indices match no case below and are dropped.
   always_comb begin
      for (int v = 0; v < VOICES; v++) begin
         osc_count_d[v] = osc_count_q[v];
         atk_inc_d[v]   = atk_inc_q[v];
         dec_dec_d[v]   = dec_dec_q[v];
         sus_lvl_d[v]   = sus_lvl_q[v];
         rel_dec_d[v]   = rel_dec_q[v];
         osc_wr[v]      = 1'b0;
         if (cfg_we && cfg_voice == 3'(v)) begin
            case (cfg_reg)
               3'd0: begin
                  osc_count_d[v] = cfg_wdata;
                  osc_wr[v]      = 1'b1;
               end
               3'd1: atk_inc_d[v] = cfg_wdata[ENV_W-1:0];
               3'd2: dec_dec_d[v] = cfg_wdata[ENV_W-1:0];
               3'd3: sus_lvl_d[v] = cfg_wdata[ENV_W-1:0];
               3'd4: rel_dec_d[v] = cfg_wdata[ENV_W-1:0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      for (int v = 0; v < VOICES; v++) begin
         cnt_d[v]   = cnt_q[v] + CNT_W'(1);
         phase_d[v] = phase_q[v];
         if (osc_wr[v] || osc_count_q[v] == '0) begin
            cnt_d[v]   = '0;
            phase_d[v] = 1'b0;
         end else if (cnt_q[v] == osc_count_q[v]) begin
            cnt_d[v]   = '0;
            phase_d[v] = ~phase_q[v];
         end
      end
   end

   // Gate-driven transitions hold env for that tick; the new state's rule applies from the next.
   always_comb begin
      for (int v = 0; v < VOICES; v++) begin
         atk_sum[v]     = {1'b0, env_q[v]} + {1'b0, atk_inc_q[v]};
         dec_diff[v]    = {1'b0, env_q[v]} - {1'b0, dec_dec_q[v]};
         rise[v]        = gate[v] & ~gate_prev_q[v];
         state_d[v]     = state_q[v];
         env_d[v]       = env_q[v];
         gate_prev_d[v] = gate_prev_q[v];
         if (tick) begin
            gate_prev_d[v] = gate[v];
            case (state_q[v])
               IDLE: begin
                  env_d[v] = '0;
                  if (rise[v]) state_d[v] = ATTACK;
               end
               ATTACK: begin
                  if (!gate[v]) begin
                     state_d[v] = RELEASE;
                  end else if (atk_inc_q[v] == '0 || atk_sum[v] >= {1'b0, ENV_MAX}) begin
                     if (ENV_MAX <= sus_lvl_q[v]) begin
                        state_d[v] = SUSTAIN;
                        env_d[v]   = sus_lvl_q[v];
                     end else begin
                        state_d[v] = DECAY;
                        env_d[v]   = ENV_MAX;
                     end
                  end else begin
                     env_d[v] = atk_sum[v][ENV_W-1:0];
                  end
               end
               DECAY: begin
                  if (!gate[v]) begin
                     state_d[v] = RELEASE;
                  end else if (dec_dec_q[v] == '0 || dec_diff[v][ENV_W] ||
                               dec_diff[v][ENV_W-1:0] <= sus_lvl_q[v]) begin
                     state_d[v] = SUSTAIN;
                     env_d[v]   = sus_lvl_q[v];
                  end else begin
                     env_d[v] = dec_diff[v][ENV_W-1:0];
                  end
               end
               SUSTAIN: begin
                  if (!gate[v]) state_d[v] = RELEASE;
                  else          env_d[v]   = sus_lvl_q[v];
               end
               RELEASE: begin
                  if (rise[v]) begin
                     state_d[v] = ATTACK;
                  end else if (rel_dec_q[v] == '0 || env_q[v] <= rel_dec_q[v]) begin
                     state_d[v] = IDLE;
                     env_d[v]   = '0;
                  end else begin
                     env_d[v] = env_q[v] - rel_dec_q[v];
                  end
               end
               default: begin
                  state_d[v] = IDLE;
                  env_d[v]   = '0;
               end
            endcase
         end
         active_d[v] = (state_d[v] != IDLE);
      end
   end

   always_comb begin
      sum = '0;
      for (int v = 0; v < VOICES; v++) begin
         if (phase_q[v]) sum = sum + SUM_W'(env_q[v]);
      end
      acc_sum = {1'b0, acc_q} + {1'b0, sum};
      acc_d   = acc_sum[SUM_W-1:0];
      data_d  = acc_sum[SUM_W];
      if (mute) begin
         acc_d  = '0;
         data_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the config arrays are a handful of flops, not RAM, so they reset with everything else.
         for (int v = 0; v < VOICES; v++) begin
            osc_count_q[v] <= '0;
            atk_inc_q[v]   <= '0;
            dec_dec_q[v]   <= '0;
            sus_lvl_q[v]   <= '0;
            rel_dec_q[v]   <= '0;
            cnt_q[v]       <= '0;
            env_q[v]       <= '0;
            state_q[v]     <= IDLE;
         end
         phase_q     <= '0;
         gate_prev_q <= '0;
         active_q    <= '0;
         div_q       <= '0;
         acc_q       <= '0;
         data_q      <= 1'b0;
      end else begin
         for (int v = 0; v < VOICES; v++) begin
            osc_count_q[v] <= osc_count_d[v];
            atk_inc_q[v]   <= atk_inc_d[v];
            dec_dec_q[v]   <= dec_dec_d[v];
            sus_lvl_q[v]   <= sus_lvl_d[v];
            rel_dec_q[v]   <= rel_dec_d[v];
            cnt_q[v]       <= cnt_d[v];
            env_q[v]       <= env_d[v];
            state_q[v]     <= state_d[v];
         end
         phase_q     <= phase_d;
         gate_prev_q <= gate_prev_d;
         active_q    <= active_d;
         div_q       <= div_d;
         acc_q       <= acc_d;
         data_q      <= data_d;
      end
   end
endmodule

// File: tb/tb_poly_synth_core.sv
// tb_poly_synth_core: directed bench for poly_synth_core with an expected-value queue
// filled at stimulus time and drained as DUT outputs are sampled on the falling edge.
module tb_poly_synth_core;
   localparam int VOICES   = 4;
   localparam int CNT_W    = 12;
   localparam int ENV_W    = 8;
   localparam int PRESCALE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [2:0]        cfg_voice;
   logic [2:0]        cfg_reg;
   logic [CNT_W-1:0]  cfg_wdata;
   logic [VOICES-1:0] gate;
   logic              mute;
   logic              data;
   logic [VOICES-1:0] active;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   ones  = 0;

   poly_synth_core #(
      .VOICES(VOICES), .CNT_W(CNT_W), .ENV_W(ENV_W), .PRESCALE(PRESCALE)
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_reg(cfg_reg),
      .cfg_wdata(cfg_wdata), .gate(gate), .mute(mute), .data(data), .active(active)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic expect_val(input string tag, input logic [31:0] val);
      exp_q.push_back('{tag, val});
   endtask

   task automatic check_obs(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      expect_val(tag, exp);
      check_obs(obs);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
         ones += int'(data);
      end
   endtask

   // Returns at the falling edge right after the next envelope tick update.
   task automatic next_tick();
      do step(1); while (cyc % PRESCALE != 0);
   endtask

   task automatic cfg_write(input int v, input int r, input int d);
      cfg_we    = 1'b1;
      cfg_voice = 3'(v);
      cfg_reg   = 3'(r);
      cfg_wdata = CNT_W'(d);
      step(1);
      cfg_we    = 1'b0;
   endtask

   initial begin
      int traj [9]  = '{64, 128, 192, 255, 223, 191, 159, 128, 128};
      int rel  [7]  = '{112, 96, 80, 64, 48, 32, 16};
      int m_acc;
      int t;

      rst = 1'b1; cfg_we = 1'b0; cfg_voice = '0; cfg_reg = '0; cfg_wdata = '0;
      gate = '0; mute = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_data", 32'(data), 0);
      check("rst_active", 32'(active), 0);
      rst = 1'b0;
      cyc = 0;

      // Idle after reset
      ones = 0;
      step(1000);
      check("idle_data_ones", ones, 0);
      check("idle_active", 32'(active), 0);

      // Configuration and ignored writes
      cfg_write(0, 1, 64);
      check("cfg_write_next_cycle", 32'(dut.atk_inc_q[0]), 64);
      cfg_write(0, 2, 32);
      cfg_write(0, 3, 128);
      cfg_write(0, 4, 16);
      cfg_write(5, 1, 8'hAA);
      check("cfg_voice5_no_alias", 32'(dut.atk_inc_q[1]), 0);
      cfg_write(0, 6, 12'h055);
      cfg_write(0, 5, 12'h0AA);
      check("cfg_reg6_ignored",
            {dut.atk_inc_q[0], dut.dec_dec_q[0], dut.sus_lvl_q[0], dut.rel_dec_q[0]},
            32'h4020_8010);
      check("cfg_osc_unchanged", 32'(dut.osc_count_q[0]), 0);

      // ADSR trajectory with the oscillator off, so the output stays silent
      ones = 0;
      gate[0] = 1'b1;
      next_tick();
      check("adsr_enter_attack_env", 32'(dut.env_q[0]), 0);
      check("adsr_active_set", 32'(active), 1);
      foreach (traj[i]) begin
         next_tick();
         check($sformatf("adsr_traj_%0d", i), 32'(dut.env_q[0]), 32'(traj[i]));
      end
      gate[0] = 1'b0;
      next_tick();
      check("adsr_release_hold", 32'(dut.env_q[0]), 128);
      foreach (rel[i]) begin
         next_tick();
         check($sformatf("adsr_rel_%0d", i), 32'(dut.env_q[0]), 32'(rel[i]));
      end
      check("adsr_rel_active", 32'(active), 1);
      next_tick();
      check("adsr_rel_zero", 32'(dut.env_q[0]), 0);
      check("adsr_idle_active", 32'(active), 0);
      check("silent_osc0", ones, 0);

      // Retrigger from RELEASE continues from the current envelope
      gate[0] = 1'b1;
      repeat (5) next_tick();
      check("retrig_peak", 32'(dut.env_q[0]), 255);
      gate[0] = 1'b0;
      repeat (4) next_tick();
      check("retrig_rel_207", 32'(dut.env_q[0]), 207);
      gate[0] = 1'b1;
      next_tick();
      check("retrig_hold", 32'(dut.env_q[0]), 207);
      next_tick();
      check("retrig_continue", 32'(dut.env_q[0]), 255);
      check("retrig_active", 32'(active), 1);
      gate[0] = 1'b0;
      repeat (40) next_tick();
      check("retrig_back_idle", 32'(active), 0);

      // Oscillator
      cfg_write(0, 1, 0);
      cfg_write(0, 2, 0);
      cfg_write(0, 3, 255);
      gate[0] = 1'b1;
      next_tick();
      check("osc_active_first_tick", 32'(active), 1);
      next_tick();
      check("osc_env_full", 32'(dut.env_q[0]), 255);
      cfg_write(0, 0, 9);
      check("osc_write_clear", {31'd0, dut.phase_q[0]} | 32'(dut.cnt_q[0]), 0);
      step(9);
      check("osc_phase_lo_9", 32'(dut.phase_q[0]), 0);
      step(1);
      check("osc_phase_hi_10", 32'(dut.phase_q[0]), 1);
      step(5);
      check("osc_cnt_mid", 32'(dut.cnt_q[0]), 5);
      cfg_write(0, 0, 9);
      check("osc_rewrite_cnt", 32'(dut.cnt_q[0]), 0);
      check("osc_rewrite_phase", 32'(dut.phase_q[0]), 0);
      step(10);
      check("osc_phase_hi_again", 32'(dut.phase_q[0]), 1);
      step(10);
      check("osc_phase_lo_again", 32'(dut.phase_q[0]), 0);

      // Output density over the low and high half-periods of a long oscillator
      cfg_write(0, 0, 4095);
      ones = 0;
      step(1024);
      check("density_low", ones, 0);
      step(3076);
      ones = 0;
      step(1024);
      check("density_high_255pm1", 32'(ones >= 254 && ones <= 256), 1);

      // Mute with all four voices full and high
      for (int v = 1; v < VOICES; v++) cfg_write(v, 3, 255);
      gate = '1;
      repeat (3) next_tick();
      for (int v = 0; v < VOICES; v++) cfg_write(v, 0, 4095);
      step(4100);
      check("mute_pre_active", 32'(active), 32'hF);
      mute = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check($sformatf("mute_data_%0d", i), 32'(data), 0);
      end
      check("mute_acc_zero", 32'(dut.acc_q), 0);
      check("mute_active", 32'(active), 32'hF);
      mute = 1'b0;
      m_acc = 0;
      for (int i = 0; i < 12; i++) begin
         t     = m_acc + 4 * 255;
         m_acc = t % 1024;
         expect_val($sformatf("post_mute_data_%0d", i), 32'(t / 1024));
      end
      for (int i = 0; i < 12; i++) begin
         step(1);
         check_obs(32'(data));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/poly_synth_core.md
Name: poly_synth_core

Overview:
- Multi-voice successor to the single-voice synth core.
- VOICES independent square-wave oscillators, each with its own ADSR envelope.
- Voices are summed and converted to a 1-bit output by a first-order sigma-delta modulator.
- Runs on the 20.48 MHz system clock; configuration arrives over a flat register write port driven by the SPI front end.

Parameters:
- VOICES, 4, number of voices (1..8).
- CNT_W, 12, oscillator half-period counter width.
- ENV_W, 8, envelope/amplitude width.
- PRESCALE, 256, system clocks per envelope tick (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  register write strobe.
- cfg_voice  in  3  target voice index.
- cfg_reg  in  3  register index within voice.
- cfg_wdata  in  CNT_W  write data (ENV_W regs use low bits).
- gate  in  VOICES  per-voice note gate (level).
- mute  in  1  force output silent.
- data  out  1  sigma-delta bitstream.
- active  out  VOICES  voice envelope not IDLE.

Behaviour:
- **Reset:** clk and rst only; rst is synchronous and active-high. All config regs, counters, phases, envelopes, the tick divider and the accumulator go to 0. All states go to IDLE. data=0, active=0.
- **Config registers** (per voice):
  - 0 osc_count (CNT_W).
  - 1 atk_inc.
  - 2 dec_dec.
  - 3 sus_lvl.
  - 4 rel_dec (ENV_W each).
  - A write takes effect the cycle after cfg_we.
  - cfg_voice≥VOICES or cfg_reg≥5: write ignored.
  - Writing osc_count also clears that voice's counter and phase.
- **Oscillator:**
  - Counter increments every clk. When counter==osc_count: counter←0 and phase toggles.
  - osc_count==0: counter and phase held 0, so the voice is silent.
- **Envelope tick:** a shared divider pulses tick for 1 clk every PRESCALE clks. The first tick occurs PRESCALE clks after reset release.
- **ADSR** (updates only on tick; gate sampled on tick; rising edge = gate high now and low at the previous tick):
  - IDLE: env=0. Rising edge → ATTACK.
  - ATTACK: env←min(env+atk_inc, 2^ENV_W−1). On reaching max → DECAY.
  - DECAY: env←max(env−dec_dec, sus_lvl). On reaching sus_lvl → SUSTAIN.
  - SUSTAIN: env←sus_lvl. A sus_lvl change is tracked on the next tick.
  - RELEASE: env←max(env−rel_dec, 0). On reaching 0 → IDLE.
  - Gate low in ATTACK/DECAY/SUSTAIN → RELEASE on that tick.
  - Rising edge in RELEASE → ATTACK, continuing from the current env (no reset to 0).
  - Increment/decrement of 0 means instantaneous: the target is reached in one tick.
  - If env is already ≤ sus_lvl when entering DECAY → SUSTAIN with env←sus_lvl.
- **active[v]:** asserted when state≠IDLE, registered with the state.
- **Mixer and modulator:**
  - sample_v = phase_v ? env_v : 0.
  - sum = Σ sample_v, width SUM_W = ENV_W+clog2(VOICES), no overflow possible.
  - Every clk: {carry,acc} ← acc + sum over SUM_W+1 bits; data ← carry (registered).
  - Output density = sum/2^SUM_W.
- **mute:** acc←0 and data←0 while high. Oscillators and envelopes keep running. Output resumes the cycle after mute falls.
- **Latency:** phase/env change to data effect is one clk.

Test Plan:
- **Reset:** rst high 2 clks → data=0, active=0. After release with no writes, data stays 0 for 1000 clks.
- **Oscillator:** VOICES=4, PRESCALE=4. Voice0 osc_count=9, atk_inc=0, sus_lvl=255, dec_dec=0, gate0=1 → active[0]=1 after first tick. Phase toggles every 10 clks. data density is 0 during low half-period and 255/1024 ±1 bit per 1024 clks during high half.
- **ADSR trajectory:** atk_inc=64, dec_dec=32, sus_lvl=128, rel_dec=16, gate0 rises → env per tick 64,128,192,255,223,191,159,128,128. Gate0 low → 112,96,…,0, then IDLE and active[0]=0.
- **Retrigger:** same settings; gate0 low at env=255 then high again after 3 ticks (env=207) → ATTACK continues 255 on the next tick, not from 0.
- **Config edge cases:** cfg_voice=5 write ignored (all regs unchanged). cfg_reg=6 ignored. Rewriting osc_count mid-period → counter and phase 0 the next clk.
- **Mute:** all 4 voices at env=255, phase high, mute pulsed 5 clks → data=0 during mute and for the cycle of release; acc restarts from 0; active unchanged.
